// File: rtl/vram_arbiter.sv
// Screen VRAM arbiter: VGA reads have strict priority, and CPU writes are queued in a FIFO that drains on VGA-idle cycles.
// The optional CPU read port is enabled by defining VRAM_CPU_READ_EN.
module vram_arbiter #(
  parameter int ADDR_W     = 13,
  parameter int DATA_W     = 16,
  parameter int WBUF_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vga_rden,
  input  logic [ADDR_W-1:0] vga_raddr,
  output logic [DATA_W-1:0] vga_rdata,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_wready,
  output logic              wbuf_empty,
`ifdef VRAM_CPU_READ_EN
  input  logic              cpu_re,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
`endif
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int PTR_W = $clog2(WBUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    GNT_IDLE,
    GNT_VGA,
    GNT_CPU_RD,
    GNT_DRAIN
  } grant_t;

  grant_t grant;

  logic [ADDR_W-1:0] fifo_addr [WBUF_DEPTH];
  logic [DATA_W-1:0] fifo_data [WBUF_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] hold_addr;
  logic [DATA_W-1:0] hold_wdata;
  logic              vga_rd_d;

  assign cpu_wready = (count != CNT_W'(WBUF_DEPTH));
  assign wbuf_empty = (count == '0);
  assign push       = cpu_we && cpu_wready;
  assign pop        = (grant == GNT_DRAIN);

`ifdef VRAM_CPU_READ_EN
  logic rd_stage1;
  logic rd_busy;
  assign rd_busy = rd_stage1 || cpu_rvalid;
`endif

  // Reset masks every grant so that no queued entry can reach the bus while reset is asserted.
  always_comb begin
    grant = GNT_IDLE;
    if (reset)
      grant = GNT_IDLE;
    else if (vga_rden)
      grant = GNT_VGA;
`ifdef VRAM_CPU_READ_EN
    else if (cpu_re && wbuf_empty && !rd_busy)
      grant = GNT_CPU_RD;
`endif
    else if (!wbuf_empty)
      grant = GNT_DRAIN;
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = hold_addr;
    mem_wdata = hold_wdata;
    unique case (grant)
      GNT_VGA: begin
        mem_en   = 1'b1;
        mem_addr = vga_raddr;
      end
      GNT_CPU_RD: begin
        mem_en   = 1'b1;
        mem_addr = cpu_addr;
      end
      GNT_DRAIN: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = fifo_addr[rd_ptr];
        mem_wdata = fifo_data[rd_ptr];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= cpu_addr;
      fifo_data[wr_ptr] <= cpu_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      hold_addr  <= '0;
      hold_wdata <= '0;
      vga_rd_d   <= 1'b0;
      vga_rdata  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      hold_addr  <= mem_addr;
      hold_wdata <= mem_wdata;
      vga_rd_d   <= (grant == GNT_VGA);
      if (vga_rd_d) vga_rdata <= mem_rdata;
    end
  end

`ifdef VRAM_CPU_READ_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_stage1  <= 1'b0;
      cpu_rvalid <= 1'b0;
      cpu_rdata  <= '0;
    end else begin
      rd_stage1  <= (grant == GNT_CPU_RD);
      cpu_rvalid <= rd_stage1;
      if (rd_stage1) cpu_rdata <= mem_rdata;
    end
  end
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: a queue-based transaction model predicts every bus cycle.
// A small VRAM behavioural memory answers the mem_* port.
module tb_vram_arbiter;

  localparam int ADDR_W = 13;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              vga_rden;
  logic [ADDR_W-1:0] vga_raddr;
  logic [DATA_W-1:0] vga_rdata;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_wready;
  logic              wbuf_empty;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;
`ifdef VRAM_CPU_READ_EN
  logic              cpu_re = 1'b0;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_rvalid;
`endif

  always #5 clk = ~clk;

  vram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WBUF_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .vga_rden   (vga_rden),
    .vga_raddr  (vga_raddr),
    .vga_rdata  (vga_rdata),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_wready (cpu_wready),
    .wbuf_empty (wbuf_empty),
`ifdef VRAM_CPU_READ_EN
    .cpu_re     (cpu_re),
    .cpu_rdata  (cpu_rdata),
    .cpu_rvalid (cpu_rvalid),
`endif
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // Power-up VRAM contents; location 0x0020 holds the known word used by the read test.
  function automatic logic [DATA_W-1:0] init_word(input logic [ADDR_W-1:0] a);
    if (a == 13'h0020) return 16'hBEEF;
    return {3'b000, a} ^ 16'hA5C3;
  endfunction

  // VRAM behavioural memory: one-cycle read latency, written words tracked separately.
  logic [DATA_W-1:0] vram    [8192];
  bit                vram_wr [8192];

  function automatic logic [DATA_W-1:0] vram_peek(input logic [ADDR_W-1:0] a);
    return vram_wr[a] ? vram[a] : init_word(a);
  endfunction

  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      vram[mem_addr]    <= mem_wdata;
      vram_wr[mem_addr] <= 1'b1;
    end
    if (mem_en && !mem_we) mem_rdata <= vram_peek(mem_addr);
  end

  // Reference model state
  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } wr_t;

  wr_t               q [$];
  logic [DATA_W-1:0] ref_mem [8192];
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W-1:0] m_vga;
  logic              p1_valid;
  logic [DATA_W-1:0] p1_val;
  logic              obs_ready;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    else
      n_pass++;
  endtask

  // One clock cycle: predict and compare at the falling edge, advance the model at the rising edge.
  task automatic step();
    logic              e_en, e_we, e_rd, do_pop, do_push, e_ready;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_wdata;
    @(negedge clk);
    e_en = 1'b0; e_we = 1'b0; e_rd = 1'b0; do_pop = 1'b0;
    e_addr = m_addr; e_wdata = m_wdata;
    if (!reset) begin
      if (vga_rden) begin
        e_en = 1'b1; e_rd = 1'b1; e_addr = vga_raddr;
      end else if (q.size() > 0) begin
        e_en = 1'b1; e_we = 1'b1; do_pop = 1'b1;
        e_addr = q[0].a; e_wdata = q[0].d;
      end
    end
    e_ready = (q.size() != DEPTH);
    do_push = cpu_we && e_ready && !reset;
    obs_ready = cpu_wready;
    check_val("mem_en", 32'(mem_en), 32'(e_en));
    check_val("mem_we", 32'(mem_we), 32'(e_we));
    check_val("mem_addr", 32'(mem_addr), 32'(e_addr));
    check_val("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
    check_val("cpu_wready", 32'(cpu_wready), 32'(e_ready));
    check_val("wbuf_empty", 32'(wbuf_empty), 32'(q.size() == 0));
    check_val("vga_rdata", 32'(vga_rdata), 32'(m_vga));
    @(posedge clk);
    if (reset) begin
      q.delete();
      m_addr = '0; m_wdata = '0; m_vga = '0; p1_valid = 1'b0;
    end else begin
      if (p1_valid) m_vga = p1_val;
      p1_valid = e_rd;
      p1_val   = ref_mem[vga_raddr];
      if (do_pop) begin
        ref_mem[q[0].a] = q[0].d;
        void'(q.pop_front());
      end
      if (do_push) q.push_back('{a: cpu_addr, d: cpu_wdata});
      m_addr  = e_addr;
      m_wdata = e_wdata;
    end
    #1;
  endtask

  task automatic drain_idle(input string tag);
    int unsigned n = 0;
    vga_rden = 1'b0; cpu_we = 1'b0;
    while (q.size() > 0 && n < 50) begin
      step();
      n++;
    end
    step();
    check_val(tag, 32'(wbuf_empty), 32'd1);
  endtask

  logic [DATA_W-1:0] saved [3];

  initial begin
    int unsigned w;
    int unsigned n;
    logic        pend;

    for (int i = 0; i < 8192; i++) ref_mem[i] = init_word(ADDR_W'(i));
    m_addr = '0; m_wdata = '0; m_vga = '0; p1_valid = 1'b0; p1_val = '0;
    reset = 1'b1; vga_rden = 1'b0; vga_raddr = '0;
    cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;

    // Reset: first edge without checks (outputs start unknown), then two checked cycles
    @(posedge clk); #1;
    step(); step();
    reset = 1'b0;
    check_val("rst_mem_en", 32'(mem_en), 32'd0);
    check_val("rst_wready", 32'(cpu_wready), 32'd1);
    check_val("rst_empty", 32'(wbuf_empty), 32'd1);
    check_val("rst_vga_rdata", 32'(vga_rdata), 32'd0);

    // VGA read of 0x0020, visible two cycles later
    vga_rden = 1'b1; vga_raddr = 13'h0020;
    step();
    vga_rden = 1'b0;
    step();
    check_val("vga_beef", 32'(vga_rdata), 32'hBEEF);
    step();

    // Idle write reaches the bus on the following cycle
    cpu_we = 1'b1; cpu_addr = 13'h1FFF; cpu_wdata = 16'h1234;
    step();
    cpu_we = 1'b0;
    check_val("idle_wr_en", 32'(mem_we), 32'd1);
    step();
    check_val("idle_wr_empty", 32'(wbuf_empty), 32'd1);
    check_val("idle_wr_vram", 32'(vram_peek(13'h1FFF)), 32'h1234);

    // Contention: 20 cycles of VGA reads while the CPU offers 5 writes
    w = 0;
    for (int c = 0; c < 20; c++) begin
      vga_rden = 1'b1; vga_raddr = ADDR_W'($urandom);
      cpu_we = (w < 5); cpu_addr = ADDR_W'(13'h0300 + w); cpu_wdata = 16'(16'hC000 + w);
      step();
      if (cpu_we && obs_ready) w++;
    end
    check_val("cont_accepted", 32'(w), 32'd4);
    check_val("cont_wready", 32'(cpu_wready), 32'd0);
    vga_rden = 1'b0;
    n = 0;
    while (w < 5 && n < 20) begin
      step();
      if (cpu_we && obs_ready) w++;
      n++;
    end
    check_val("cont_fifth", 32'(w), 32'd5);
    drain_idle("cont_drained");
    for (int i = 0; i < 5; i++)
      check_val("cont_vram", 32'(vram_peek(ADDR_W'(13'h0300 + i))), 32'(16'hC000 + i));

    // Ten back-to-back writes wrap the FIFO pointers
    w = 0; n = 0;
    while (w < 10 && n < 40) begin
      cpu_we = 1'b1; cpu_addr = ADDR_W'(13'h0100 + w); cpu_wdata = 16'(16'h0100 + w);
      step();
      if (obs_ready) w++;
      n++;
    end
    drain_idle("wrap_drained");
    for (int i = 0; i < 10; i++)
      check_val("wrap_vram", 32'(vram_peek(ADDR_W'(13'h0100 + i))), 32'(16'h0100 + i));

    // Queue 3 writes under VGA reads, then reset: none may be written
    for (int i = 0; i < 3; i++) saved[i] = vram_peek(ADDR_W'(13'h0200 + i));
    vga_rden = 1'b1;
    for (int i = 0; i < 3; i++) begin
      vga_raddr = ADDR_W'($urandom);
      cpu_we = 1'b1; cpu_addr = ADDR_W'(13'h0200 + i); cpu_wdata = 16'hDEAD;
      step();
    end
    cpu_we = 1'b0;
    check_val("rst_mid_count", 32'(wbuf_empty), 32'd0);
    reset = 1'b1; vga_rden = 1'b0;
    step(); step();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) step();
    for (int i = 0; i < 3; i++)
      check_val("rst_mid_vram", 32'(vram_peek(ADDR_W'(13'h0200 + i))), 32'(saved[i]));

    // Randomized traffic over a small address window
    pend = 1'b0;
    for (int c = 0; c < 400; c++) begin
      vga_rden  = ($urandom_range(0, 3) != 0) && (c % 64 < 48);
      vga_raddr = ADDR_W'($urandom_range(0, 63));
      if (!pend) begin
        cpu_we    = ($urandom_range(0, 1) == 1);
        cpu_addr  = ADDR_W'($urandom_range(0, 63));
        cpu_wdata = 16'($urandom);
      end
      step();
      pend = cpu_we && !obs_ready;
    end
    drain_idle("rand_drained");
    for (int i = 0; i < 64; i++)
      check_val("rand_vram", 32'(vram_peek(ADDR_W'(i))), 32'(ref_mem[i]));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
